// File: rtl/param_queue_controller.sv
// param_queue_controller
//   Single-clock circular FIFO with show-ahead read port. Pointers carry one
//   extra wrap bit so full/empty are exact. Provides occupancy count,
//   almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enq/deq      enqueue / dequeue requests
//   data_in      write data, taken on an accepted enqueue
//   data_out     head entry (combinational, valid when !empty)
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        occupancy 0..DEPTH
//   overflow     sticky: enq while full without a same-cycle deq
//   underflow    sticky: deq while empty
//   err_clr      synchronous clear of overflow/underflow (wins over a set)
//   flush        (only with QCTRL_FLUSH_EN) empties the queue; beats enq/deq
//
// Build option: define QCTRL_FLUSH_EN to add the flush input.

module param_queue_controller #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq,
  input  logic              deq,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
`ifdef QCTRL_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              err_clr
);

  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] head_q, head_d;
  logic [ADDR_W:0] tail_q, tail_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            wr_ok, rd_ok;
  logic            flush_i;

`ifdef QCTRL_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  always_comb begin
    // Same index with differing wrap bits means the tail has lapped the head.
    full         = (head_q[ADDR_W-1:0] == tail_q[ADDR_W-1:0]) &&
                   (head_q[ADDR_W] != tail_q[ADDR_W]);
    empty        = (head_q == tail_q);
    almost_full  = (count_q >= AF_LVL);
    almost_empty = (count_q <= AE_LVL);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
    data_out     = mem[head_q[ADDR_W-1:0]];
  end

  always_comb begin
    // A dequeue on a full queue frees the slot the new word lands in.
    wr_ok       = enq && (!full || deq) && !flush_i;
    rd_ok       = deq && !empty && !flush_i;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (enq && full && !deq);
    underflow_d = underflow_q | (deq && empty);

    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    if (flush_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (wr_ok) tail_d = tail_q + ONE;
      if (rd_ok) head_d = head_q + ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; a write racing reset is orphaned by the cleared pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[tail_q[ADDR_W-1:0]] <= data_in;
  end

endmodule

// File: tb/tb_param_queue_controller.sv
module tb_param_queue_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enq, deq, err_clr, flush;
  logic [7:0] data_in, data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  // Second instance, DEPTH=4, for pointer wrap coverage.
  logic       enq4, deq4;
  logic [7:0] din4, dout4;
  logic       full4, empty4, af4, ae4, ovf4, udf4;
  logic [2:0] count4;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  always #5 clk = ~clk;

  param_queue_controller #(.DATA_W(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow),
`ifdef QCTRL_FLUSH_EN
    .flush(flush),
`endif
    .err_clr(err_clr)
  );

  param_queue_controller #(.DATA_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enq(enq4), .deq(deq4), .data_in(din4),
    .data_out(dout4), .full(full4), .empty(empty4),
    .almost_full(af4), .almost_empty(ae4), .count(count4),
    .overflow(ovf4), .underflow(udf4),
`ifdef QCTRL_FLUSH_EN
    .flush(1'b0),
`endif
    .err_clr(1'b0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq = 0; deq = 0; err_clr = 0; flush = 0;
  endtask

  task automatic test_reset();
    idle(); enq4 = 0; deq4 = 0; din4 = 0; data_in = 0;
    rst_n = 0;
    #12;
    chk_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
    chk_cnt++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else pass_cnt++;
    chk_cnt++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
    chk_cnt++; if ({almost_empty, almost_full} !== 2'b10) $display("FAIL reset_ae_af: got %b want 10", {almost_empty, almost_full}); else pass_cnt++;
    chk_cnt++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {overflow, underflow}); else pass_cnt++;
    @(negedge clk); rst_n = 1;
    tick();
  endtask

  task automatic test_fill();
    for (int unsigned i = 0; i < 8; i++) begin
      enq = 1; data_in = 8'h11 + 8'(i);
      tick();
      chk_cnt++; if (count !== 4'(i + 1)) $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); else pass_cnt++;
      chk_cnt++; if (almost_full !== (i + 1 >= 6)) $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i + 1 >= 6)); else pass_cnt++;
      chk_cnt++; if (almost_empty !== (i + 1 <= 2)) $display("FAIL fill_ae[%0d]: got %b want %b", i, almost_empty, (i + 1 <= 2)); else pass_cnt++;
      chk_cnt++; if (data_out !== 8'h11) $display("FAIL fill_head[%0d]: got %h want 11", i, data_out); else pass_cnt++;
    end
    idle();
    chk_cnt++; if ({full, empty} !== 2'b10) $display("FAIL fill_full: got %b want 10", {full, empty}); else pass_cnt++;
  endtask

  task automatic test_overflow();
    enq = 1; data_in = 8'hAA;
    tick(); idle();
    chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else pass_cnt++;
    chk_cnt++; if (count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", count); else pass_cnt++;
    chk_cnt++; if (data_out !== 8'h11) $display("FAIL ovf_head: got %h want 11", data_out); else pass_cnt++;
  endtask

  task automatic test_full_enq_deq();
    enq = 1; deq = 1; data_in = 8'h55;
    tick(); idle();
    chk_cnt++; if (count !== 4'd8) $display("FAIL fed_count: got %0d want 8", count); else pass_cnt++;
    chk_cnt++; if (data_out !== 8'h12) $display("FAIL fed_head: got %h want 12", data_out); else pass_cnt++;
    // Drain: 0x12..0x18 then the word written into the vacated slot, never 0xAA.
    for (int unsigned i = 0; i < 7; i++) begin
      chk_cnt++; if (data_out !== 8'h12 + 8'(i)) $display("FAIL drain[%0d]: got %h want %h", i, data_out, 8'h12 + 8'(i)); else pass_cnt++;
      deq = 1; tick(); idle();
    end
    chk_cnt++; if (data_out !== 8'h55) $display("FAIL drain_last: got %h want 55", data_out); else pass_cnt++;
    chk_cnt++; if (count !== 4'd1) $display("FAIL drain_count: got %0d want 1", count); else pass_cnt++;
    deq = 1; tick(); idle();
    chk_cnt++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else pass_cnt++;
    err_clr = 1; tick(); idle();
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_clr: got %b want 0", overflow); else pass_cnt++;
  endtask

  task automatic test_underflow();
    deq = 1; tick(); idle();
    chk_cnt++; if (underflow !== 1'b1) $display("FAIL udf_set: got %b want 1", underflow); else pass_cnt++;
    chk_cnt++; if (count !== 4'd0) $display("FAIL udf_count: got %0d want 0", count); else pass_cnt++;
    // err_clr beats a simultaneous set.
    err_clr = 1; deq = 1; tick(); idle();
    chk_cnt++; if (underflow !== 1'b0) $display("FAIL udf_clr_prio: got %b want 0", underflow); else pass_cnt++;
    enq = 1; deq = 1; data_in = 8'h3C; tick(); idle();
    chk_cnt++; if (count !== 4'd1) $display("FAIL empty_ed_count: got %0d want 1", count); else pass_cnt++;
    chk_cnt++; if (data_out !== 8'h3C) $display("FAIL empty_ed_head: got %h want 3c", data_out); else pass_cnt++;
    chk_cnt++; if (underflow !== 1'b1) $display("FAIL empty_ed_udf: got %b want 1", underflow); else pass_cnt++;
    deq = 1; err_clr = 1; tick(); idle();
    chk_cnt++; if ({empty, underflow} !== 2'b10) $display("FAIL udf_cleanup: got %b want 10", {empty, underflow}); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [19:0] enq_pat = 20'b0000_0111_1111_1111_1111;
    logic [19:0] deq_pat = 20'b1111_1111_1001_1111_0000;
    logic w, r;
    for (int unsigned i = 0; i < 20; i++) begin
      enq4 = enq_pat[i]; deq4 = deq_pat[i]; din4 = 8'hA0 + 8'(i);
      w = enq4 && (q.size() < 4 || deq4);
      r = deq4 && (q.size() > 0);
      if (r) void'(q.pop_front());
      if (w) q.push_back(din4);
      tick();
      chk_cnt++; if (count4 !== 3'(q.size())) $display("FAIL wrap_count[%0d]: got %0d want %0d", i, count4, q.size()); else pass_cnt++;
      if (q.size() > 0) begin
        chk_cnt++; if (dout4 !== q[0]) $display("FAIL wrap_data[%0d]: got %h want %h", i, dout4, q[0]); else pass_cnt++;
      end
    end
    enq4 = 0; deq4 = 0;
  endtask

  task automatic test_async_reset();
    deq = 1; tick(); idle();  // plant an underflow so flag clearing is visible
    for (int unsigned i = 0; i < 5; i++) begin
      enq = 1; data_in = 8'h60 + 8'(i); tick();
    end
    idle();
    chk_cnt++; if ({count, underflow} !== {4'd5, 1'b1}) $display("FAIL pre_rst: got %0d/%b want 5/1", count, underflow); else pass_cnt++;
    enq = 1; data_in = 8'hEE;
    #2 rst_n = 0;
    #1;
    chk_cnt++; if ({empty, count} !== {1'b1, 4'd0}) $display("FAIL async_rst_cnt: got %b/%0d want 1/0", empty, count); else pass_cnt++;
    chk_cnt++; if ({overflow, underflow} !== 2'b00) $display("FAIL async_rst_flags: got %b want 00", {overflow, underflow}); else pass_cnt++;
    tick(); idle();
    @(negedge clk); rst_n = 1;
    tick();
    chk_cnt++; if ({empty, count} !== {1'b1, 4'd0}) $display("FAIL post_rst: got %b/%0d want 1/0", empty, count); else pass_cnt++;
  endtask

`ifdef QCTRL_FLUSH_EN
  task automatic test_flush();
    enq = 1; data_in = 8'hAA; tick();  // fill to 3 so a later overflow is impossible; keep flags intact check
    enq = 1; data_in = 8'hAB; tick();
    enq = 1; data_in = 8'hAC; tick();
    idle(); deq = 0;
    chk_cnt++; if (count !== 4'd3) $display("FAIL flush_pre: got %0d want 3", count); else pass_cnt++;
    flush = 1; enq = 1; data_in = 8'hBB; tick(); idle();
    chk_cnt++; if ({empty, count} !== {1'b1, 4'd0}) $display("FAIL flush: got %b/%0d want 1/0", empty, count); else pass_cnt++;
    enq = 1; data_in = 8'hCD; tick(); idle();
    chk_cnt++; if ({count, data_out} !== {4'd1, 8'hCD}) $display("FAIL flush_after: got %0d/%h want 1/cd", count, data_out); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_enq_deq();
    test_underflow();
    test_wrap();
    test_async_reset();
`ifdef QCTRL_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
